// File: rtl/sawtooth_arbiter.sv
// Round-robin front end sharing one in-order sawtooth pipeline between NREQ requesters.
// Define SAWTOOTH_ARB_ERR_EN to add the err_orphan flag and err_count counter for orphan returns.
module sawtooth_arbiter #(
    parameter int PRECISION = 32,
    parameter int NREQ      = 4,
    parameter int DEPTH     = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*PRECISION-1:0]     req_x,
    input  logic [NREQ*PRECISION-1:0]     req_epsilon,
    output logic                          st_tvalid,
    output logic [PRECISION-1:0]          st_x,
    output logic [PRECISION-1:0]          st_epsilon,
    input  logic                          st_valid,
    input  logic [PRECISION-1:0]          st_result,
    output logic                          rsp_valid,
    output logic [$clog2(NREQ)-1:0]       rsp_id,
    output logic [PRECISION-1:0]          rsp_data,
    output logic [$clog2(DEPTH):0]        inflight
`ifdef SAWTOOTH_ARB_ERR_EN
    ,
    output logic                          err_orphan,
    output logic [15:0]                   err_count
`endif
);

    localparam int IDW = $clog2(NREQ);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] cand;
    logic           found;
    logic           full;
    logic           push;
    logic           pop;

    logic [IDW-1:0] tag_mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    // Cyclic search starting at the priority pointer; the first valid requester wins.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(ptr) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Full uses registered occupancy, so a same-cycle pop never frees a slot for this grant.
    assign full = (inflight == CW'(DEPTH));
    assign push = found && !full;
    assign pop  = st_valid && (inflight != '0);

    always_comb begin
        req_ready = '0;
        if (push) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_tvalid  <= 1'b0;
            st_x       <= '0;
            st_epsilon <= '0;
            ptr        <= '0;
        end else begin
            st_tvalid <= push;
            if (push) begin
                st_x       <= req_x[32'(winner)*PRECISION +: PRECISION];
                st_epsilon <= req_epsilon[32'(winner)*PRECISION +: PRECISION];
                ptr        <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            tag_mem[wr_ptr] <= winner;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            inflight  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                rsp_id   <= tag_mem[rd_ptr];
                rsp_data <= st_result;
            end
            rsp_valid <= pop;
            case ({push, pop})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

`ifdef SAWTOOTH_ARB_ERR_EN
    logic orphan;
    assign orphan = st_valid && (inflight == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_orphan <= 1'b0;
            err_count  <= '0;
        end else if (orphan) begin
            err_orphan <= 1'b1;
            if (err_count != '1) begin
                err_count <= err_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sawtooth_arbiter.sv
// Randomized bench for sawtooth_arbiter: a queue-based reference model plus a latency-50 pipeline stand-in.
module tb_sawtooth_arbiter;

    localparam int P     = 32;
    localparam int NREQ  = 4;
    localparam int DEPTH = 64;
    localparam int LAT   = 49;   // st_tvalid to st_valid, i.e. 50 cycles after the handshake

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*P-1:0]      req_x;
    logic [NREQ*P-1:0]      req_epsilon;
    logic                   st_tvalid;
    logic [P-1:0]           st_x;
    logic [P-1:0]           st_epsilon;
    logic                   st_valid;
    logic [P-1:0]           st_result;
    logic                   rsp_valid;
    logic [1:0]             rsp_id;
    logic [P-1:0]           rsp_data;
    logic [6:0]             inflight;
`ifdef SAWTOOTH_ARB_ERR_EN
    logic                   err_orphan;
    logic [15:0]            err_count;
`endif

    sawtooth_arbiter #(.PRECISION(P), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_epsilon(req_epsilon),
        .st_tvalid(st_tvalid), .st_x(st_x), .st_epsilon(st_epsilon),
        .st_valid(st_valid), .st_result(st_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .inflight(inflight)
`ifdef SAWTOOTH_ARB_ERR_EN
        , .err_orphan(err_orphan), .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: priority index, FIFO of owners, expected registered outputs
    int          prio;
    int          tags[$];
    bit          e_tv, e_rv, e_err, post_rst;
    logic [P-1:0] e_x, e_e, e_rd;
    int          e_id, e_cnt;

    // Requesters and bench pipeline
    bit          pend [NREQ];
    logic [P-1:0] px [NREQ];
    logic [P-1:0] pe [NREQ];
    logic [P-1:0] pipe_d[$];
    int          pipe_due[$];
    logic [NREQ-1:0] mask;
    int          rate;
    bit          stall, pulse_one, rst_req, chk_en;
    int          cyc;
    int          glog[$];
    int          rsp_log[$];
    int          rsp_seen;
    logic [NREQ-1:0] last_ready;

    function automatic int pick();
        if (tags.size() >= DEPTH) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (pend[(prio + k) % NREQ]) return (prio + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic preset(input int i, input logic [P-1:0] x, input logic [P-1:0] e);
        pend[i] = 1'b1;
        px[i]   = x;
        pe[i]   = e;
    endtask

    task automatic cycle();
        int g;
        int dg;
        logic [NREQ-1:0] er;
        if (chk_en) begin
            check("st_tvalid", st_tvalid, e_tv);
            check("st_x", st_x, e_x);
            check("st_epsilon", st_epsilon, e_e);
            check("rsp_valid", rsp_valid, e_rv);
            if (e_rv || post_rst) begin
                check("rsp_id", rsp_id, e_id);
                check("rsp_data", rsp_data, e_rd);
            end
            check("inflight", inflight, tags.size());
`ifdef SAWTOOTH_ARB_ERR_EN
            check("err_orphan", err_orphan, e_err);
            check("err_count", err_count, e_cnt);
`endif
        end
        post_rst = 1'b0;
        if (rsp_valid === 1'b1) begin
            rsp_seen++;
            rsp_log.push_back(int'(rsp_id));
        end
        if (st_tvalid === 1'b1) begin
            pipe_d.push_back(st_x);
            pipe_due.push_back(cyc + LAT);
        end
        // Inputs for this cycle
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && mask[i] && ($urandom_range(99) < rate)) begin
                pend[i] = 1'b1;
                px[i]   = $urandom;
                pe[i]   = $urandom;
            end
            req_valid[i]          = pend[i] && !rst_req;
            req_x[i*P +: P]       = px[i];
            req_epsilon[i*P +: P] = pe[i];
        end
        st_valid  = 1'b0;
        st_result = $urandom;
        if (pipe_d.size() > 0 && (pulse_one || (!stall && pipe_due[0] <= cyc))) begin
            st_valid  = 1'b1;
            st_result = pipe_d.pop_front();
            void'(pipe_due.pop_front());
        end
        pulse_one = 1'b0;
        reset_n   = !rst_req;
        #1;
        g  = rst_req ? -1 : pick();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        if (chk_en) check("req_ready", req_ready, er);
        last_ready = req_ready;
        dg = -1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i] === 1'b1) dg = i;
        glog.push_back(dg);
        // Model advance over the clock edge
        if (rst_req) begin
            e_tv = 0; e_rv = 0; e_err = 0; e_cnt = 0;
            e_x = '0; e_e = '0; e_rd = '0; e_id = 0;
            tags.delete();
            prio = 0;
            post_rst = 1'b1;
            for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        end else begin
            e_rv = 1'b0;
            if (st_valid) begin
                if (tags.size() == 0) begin
                    e_err = 1'b1;
                    if (e_cnt < 65535) e_cnt++;
                end else begin
                    e_rv = 1'b1;
                    e_id = tags.pop_front();
                    e_rd = st_result;
                end
            end
            e_tv = (g >= 0);
            if (g >= 0) begin
                e_x  = px[g];
                e_e  = pe[g];
                tags.push_back(g);
                prio = (g + 1) % NREQ;
                pend[g] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
    endtask

    task automatic drain();
        int n;
        bit busy;
        mask  = '0;
        stall = 1'b0;
        n = 0;
        busy = 1'b1;
        while (busy && n < 400) begin
            cycle();
            n++;
            busy = (tags.size() > 0) || (pipe_d.size() > 0);
            for (int i = 0; i < NREQ; i++) busy = busy || pend[i];
        end
        check("drain_inflight", inflight, 0);
    endtask

    task automatic fill_to(input int level, input logic [NREQ-1:0] m);
        int n;
        mask = m; rate = 100; stall = 1'b1;
        n = 0;
        while (tags.size() < level && n < 200) begin
            cycle();
            n++;
        end
        mask = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_cyc;
        int n;
        reset_n = 1'b0; req_valid = '0; req_x = '0; req_epsilon = '0;
        st_valid = 1'b0; st_result = '0;
        mask = '0; rate = 0; stall = 0; pulse_one = 0; rst_req = 0; chk_en = 0;
        cyc = 0; rsp_seen = 0; prio = 0;
        for (int i = 0; i < NREQ; i++) begin pend[i] = 0; px[i] = '0; pe[i] = '0; end
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk_en = 1'b1;

        // Single requester, end-to-end latency
        preset(0, 32'h3F000000, 32'h3F800000);
        hs_cyc = cyc;
        cycle();
        check("single_ready", last_ready, 4'b0001);
        check("single_st_x", st_x, 32'h3F000000);
        check("single_st_eps", st_epsilon, 32'h3F800000);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin cycle(); n++; end
        check("single_latency", cyc - hs_cyc, 51);
        check("single_rsp_id", rsp_id, 0);
        check("single_rsp_data", rsp_data, 32'h3F000000);
        drain();

        // Round-robin fairness with all requesters busy
        do_reset();
        for (int i = 0; i < NREQ; i++) preset(i, 32'h40000000 | i, 32'h3F800000);
        glog.delete(); rsp_log.delete();
        mask = '1; rate = 100;
        repeat (8) cycle();
        mask = '0;
        for (int i = 0; i < 8; i++) check("rr_grant", glog[i], i % NREQ);
        drain();
        for (int i = 0; i < 8; i++) check("rr_rsp_id", rsp_log[i], i % NREQ);

        // Sparse priority: pointer at 2, only req0 and req3 valid
        do_reset();
        preset(0, $urandom, $urandom); cycle();
        preset(1, $urandom, $urandom); cycle();
        preset(0, $urandom, $urandom); preset(3, $urandom, $urandom);
        glog.delete();
        cycle(); cycle();
        check("sparse_first", glog[0], 3);
        check("sparse_second", glog[1], 0);
        drain();

        // Full FIFO with stalled pipeline
        do_reset();
        fill_to(DEPTH, '1);
        check("full_inflight", inflight, DEPTH);
        check("full_ready", req_ready, 0);
        pulse_one = 1'b1;
        cycle();
        check("full_no_grant_on_pop", last_ready, 0);
        check("full_after_pop", inflight, DEPTH - 1);
        cycle();
        check("full_resume", last_ready != 0, 1);
        drain();

        // Simultaneous push and pop at inflight=10
        do_reset();
        fill_to(10, 4'b0001);
        cycle();
        preset(2, $urandom, $urandom);
        pulse_one = 1'b1;
        cycle();
        check("pp_ready", last_ready, 4'b0100);
        check("pp_inflight", inflight, 10);
        check("pp_rsp_valid", rsp_valid, 1);
        check("pp_rsp_id", rsp_id, 0);
        drain();

        // Reset with 5 in flight; their results return as orphans
        fill_to(5, 4'b0001);
        cycle();
        do_reset();
        rsp_seen = 0;
        drain();
        check("orphan_no_rsp", rsp_seen, 0);
        check("orphan_inflight", inflight, 0);
`ifdef SAWTOOTH_ARB_ERR_EN
        check("orphan_flag", err_orphan, 1);
        check("orphan_count", err_count, 5);
`endif

        // Random traffic with random pipeline stalls
        mask = '1; rate = 35;
        for (int k = 0; k < 3000; k++) begin
            stall = ($urandom_range(99) < 30);
            cycle();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sawtooth_arbiter.md
Name: sawtooth_arbiter

Overview:
- Shares one sawtooth map pipeline between NREQ independent chaotic-state requesters, e.g. per-channel keystream generators of the image cipher.
- Grants one request per cycle using round-robin arbitration and drives the pipeline's valid/x/epsilon inputs.
- The pipeline has no ID field and returns results in order. This block therefore records each issuing requester in a tag FIFO and routes each returned result back to its owner.
- Sits between the keystream controllers and a single sawtooth pipeline instance.

Parameters:
- PRECISION, 32, operand/result width; IEEE-754 single-precision bit patterns, passed through untouched.
- NREQ, 4, number of requesters; range 2..8.
- DEPTH, 64, maximum requests in flight; must be a power of 2 and at least the pipeline latency.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; synchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant; one-hot or zero.
- req_x  in  NREQ*PRECISION  packed x operands; requester i occupies [i*PRECISION +: PRECISION].
- req_epsilon  in  NREQ*PRECISION  packed epsilon operands, same packing.
- st_tvalid  out  1  to pipeline sawtooth_tvalid.
- st_x  out  PRECISION  to pipeline x.
- st_epsilon  out  PRECISION  to pipeline epsilon.
- st_valid  in  1  from pipeline sawtooth_valid.
- st_result  in  PRECISION  from pipeline result.
- rsp_valid  out  1  response strobe.
- rsp_id  out  $clog2(NREQ)  owner of the response.
- rsp_data  out  PRECISION  returned sawtooth result.
- inflight  out  $clog2(DEPTH)+1  current tag FIFO occupancy.

Behaviour:
- Reset: synchronous and active-low, sampled on the rising edge of clk.
  - Outputs st_tvalid, rsp_valid, st_x, st_epsilon, rsp_id, rsp_data and inflight all reset to 0.
  - The round-robin pointer resets to requester 0 as highest priority.
  - The tag FIFO is emptied.
- Grant (combinational):
  - A grant is possible when any req_valid bit is set and inflight < DEPTH.
  - The winner is the first set req_valid bit at or after the priority pointer, searching cyclically upward.
  - req_ready[winner]=1; all other bits are 0.
  - req_ready is 0 everywhere when inflight==DEPTH.
  - A handshake is req_valid[i] & req_ready[i]. Requesters hold x/epsilon stable until their handshake.
- On a handshake in cycle t:
  - st_tvalid=1 in cycle t+1, with st_x/st_epsilon equal to the winner's operands.
  - The winner index is pushed into the tag FIFO.
  - The pointer moves to winner+1, wrapping modulo NREQ.
- With no handshake: st_tvalid=0 next cycle, st_x/st_epsilon hold their values, and the pointer does not move.
- Return path, on st_valid in cycle u with the FIFO non-empty:
  - The head tag is popped.
  - In cycle u+1: rsp_valid=1, rsp_id=tag, rsp_data=st_result.
  - There is no response backpressure; requesters must accept rsp_valid in any cycle.
- Orphan return (st_valid with an empty FIFO): the result is dropped, rsp_valid stays 0, and inflight stays 0.
- Simultaneous push and pop: inflight is unchanged. A pop in the same cycle does not free a slot for that cycle's grant, because the full check uses registered inflight.
- Write and read pointers wrap modulo DEPTH.
- inflight = pushes − pops. It never exceeds DEPTH and never goes below 0.
- Reset mid-operation: all tags are discarded. Pipeline results still in flight that arrive after reset are orphans and are dropped.
- Throughput: one issue per cycle and one response per cycle, sustained.

Optional Feature:
- Macro: SAWTOOTH_ARB_ERR_EN.
- When defined, adds output err_orphan (1 bit):
  - Resets to 0.
  - Sets and stays set in the cycle after an orphan st_valid.
  - Cleared only by reset.
  - Also adds output err_count (16 bits, saturating at 0xFFFF), counting orphan returns.
- When not defined, these ports do not exist, and orphans are dropped silently with the same data-path behaviour.

Test Plan:
- Single requester: req0 valid with x=0x3F000000, eps=0x3F800000.
  - Expect req_ready=0001 that cycle, st_tvalid one cycle later with the same operands.
  - Bench pipeline model (latency 50) returns 0x3F000000; expect rsp_valid 51 cycles after issue with rsp_id=0 and rsp_data=0x3F000000.
- Round-robin fairness: all four req_valid held high for 8 cycles.
  - Expect grants in order 0,1,2,3,0,1,2,3.
  - Expect responses with rsp_id in the same order and data matching each requester's distinct x.
- Sparse priority: pointer at 2 with only req0 and req3 valid.
  - Expect grant to 3, then 0 on the next cycle.
- Full: DEPTH=64 with a stalled bench pipeline.
  - After 64 issues expect inflight=64 and req_ready=0.
  - One st_valid pulse brings inflight to 63, and a grant resumes the following cycle.
- Simultaneous push/pop at inflight=10: expect inflight stays 10 and rsp_id equals the oldest tag.
- Orphan and reset: assert reset_n=0 for one cycle with 5 requests in flight, then deliver 5 st_valid pulses.
  - Expect no rsp_valid and inflight=0.
  - With SAWTOOTH_ARB_ERR_EN defined, expect err_orphan=1 and err_count=5.
